gearbox_src_arb_24_32: RTL and testbench

- Packet-granular round-robin arbiter that shares the single 24-bit input of the 24-to-32 gearbox between two pixel sources.
- Holds a grant for a whole packet, from grant to the accepted last word.
- Inserts a fixed flush gap after each packet so the gearbox can emit its residual tail before the next packet starts.
- Recovers a stalled source with a timeout that force-terminates its packet, and keeps per-packet and total-packet counters.

---
 rtl/gearbox_24_32_pkg.sv | 24 ++
 rtl/gearbox_arb_timer.sv | 32 +++
 rtl/gearbox_src_arb_24_32.sv | 166 ++++++++++++++++
 tb/tb_gearbox_src_arb_24_32.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gearbox_24_32_pkg.sv
// Shared types and constants for the two-source arbiter in front of the 24-to-32 gearbox.
//   arb_state_e   : arbiter FSM states
//   RGB_W         : pixel word width
//   DUMMY_RGB     : word emitted when a stalled packet is force-terminated
//   DEF_FLUSH_CYC : default idle gap after every packet
//   DEF_TIMEOUT   : default stall limit in granted cycles
//   TMR_W         : width of the shared gap/timeout down-counter
package gearbox_24_32_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, FLUSH} arb_state_e;

    localparam int unsigned RGB_W         = 24;
    localparam logic [RGB_W-1:0] DUMMY_RGB = 24'h000000;
    localparam int unsigned DEF_FLUSH_CYC = 4;
    localparam int unsigned DEF_TIMEOUT   = 256;
    localparam int unsigned TMR_W         = 16;

    // Round-robin pick: on a tie the source that was not served last wins.
    function automatic logic rr_pick(input logic req0, input logic req1,
                                     input logic last_served);
        return (req0 & req1) ? ~last_served : req1;
    endfunction

endpackage

// File: rtl/gearbox_arb_timer.sv
// Loadable down-counter with a done flag, shared by the post-packet flush gap and the
// stall timeout (never active at the same time).
//   clk_200m, reset_n : clock, asynchronous active-low reset
//   load, load_val    : load the counter (takes priority over dec)
//   dec               : count down by one, stops at zero
//   done              : counter is zero
module gearbox_arb_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk_200m,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_200m or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/gearbox_src_arb_24_32.sv
// Packet-granular round-robin arbiter sharing the 24-bit gearbox input between two pixel
// sources. A grant is held from grant to the accepted last word (or a stall timeout,
// which injects a zero dummy last word), then a fixed flush gap lets the gearbox drain.
//   clk_200m, reset_n               : clock, asynchronous active-low reset
//   srcN_req/en/last/rgb, srcN_gnt  : per-source packet interface (N = 0, 1)
//   gb_en, gb_last, gb_rgb          : registered gearbox input
//   gb_sel                          : granted source, held outside GRANT
//   pkt_words, pkt_cnt              : last packet length (saturating), packet count (wraps)
//   timeout_err                     : one-cycle pulse on forced termination
module gearbox_src_arb_24_32
    import gearbox_24_32_pkg::*;
#(
    parameter int unsigned FLUSH_CYC = DEF_FLUSH_CYC,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_200m,
    input  logic             reset_n,
    input  logic             src0_req,
    input  logic             src0_en,
    input  logic             src0_last,
    input  logic [RGB_W-1:0] src0_rgb,
    output logic             src0_gnt,
    input  logic             src1_req,
    input  logic             src1_en,
    input  logic             src1_last,
    input  logic [RGB_W-1:0] src1_rgb,
    output logic             src1_gnt,
    output logic             gb_en,
    output logic             gb_last,
    output logic [RGB_W-1:0] gb_rgb,
    output logic             gb_sel,
    output logic [CNT_W-1:0] pkt_words,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             timeout_err
);

    arb_state_e       state;
    logic             last_served;
    logic [CNT_W-1:0] word_cnt;

    logic             sel_en;
    logic             sel_last;
    logic [RGB_W-1:0] sel_rgb;
    logic             any_req;
    logic             pick;
    logic             acc_last;
    logic             tmr_hit;
    logic [CNT_W-1:0] words_inc;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_dec;
    logic             tmr_done;

    always_comb begin
        sel_en    = gb_sel ? src1_en : src0_en;
        sel_last  = gb_sel ? src1_last : src0_last;
        sel_rgb   = gb_sel ? src1_rgb : src0_rgb;
        any_req   = src0_req | src1_req;
        pick      = rr_pick(src0_req, src1_req, last_served);
        acc_last  = sel_en & sel_last;
        // An accepted word always reloads the timer, so a last can never also time out.
        tmr_hit   = ~sel_en & tmr_done;
        words_inc = (word_cnt == '1) ? word_cnt : word_cnt + CNT_W'(1);

        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT - 1);
                end
            end
            GRANT: begin
                if (acc_last || tmr_hit) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(FLUSH_CYC - 1);
                end else if (sel_en) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT - 1);
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            FLUSH:   tmr_dec = 1'b1;
            default: ;
        endcase
    end

    gearbox_arb_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_200m (clk_200m),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .done     (tmr_done)
    );

    always_ff @(posedge clk_200m or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_served <= 1'b1;
            word_cnt    <= '0;
            src0_gnt    <= 1'b0;
            src1_gnt    <= 1'b0;
            gb_en       <= 1'b0;
            gb_last     <= 1'b0;
            gb_rgb      <= '0;
            gb_sel      <= 1'b0;
            pkt_words   <= '0;
            pkt_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    gb_en   <= 1'b0;
                    gb_last <= 1'b0;
                    if (any_req) begin
                        gb_sel   <= pick;
                        src0_gnt <= ~pick;
                        src1_gnt <= pick;
                        word_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    gb_en   <= sel_en;
                    gb_last <= acc_last;
                    if (sel_en) begin
                        gb_rgb <= sel_rgb;
                    end
                    if (acc_last || tmr_hit) begin
                        src0_gnt    <= 1'b0;
                        src1_gnt    <= 1'b0;
                        last_served <= gb_sel;
                        pkt_words   <= words_inc;
                        pkt_cnt     <= pkt_cnt + CNT_W'(1);
                        state       <= FLUSH;
                    end else if (sel_en) begin
                        word_cnt <= words_inc;
                    end
                    if (tmr_hit) begin
                        gb_en       <= 1'b1;
                        gb_last     <= 1'b1;
                        gb_rgb      <= DUMMY_RGB;
                        timeout_err <= 1'b1;
                    end
                end
                FLUSH: begin
                    gb_en   <= 1'b0;
                    gb_last <= 1'b0;
                    if (tmr_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gearbox_src_arb_24_32.sv
module tb_gearbox_src_arb_24_32;

    localparam int FLUSH = 4;
    localparam int TMO   = 16;

    logic        clk_200m = 1'b0;
    logic        reset_n  = 1'b0;
    logic        src0_req = 1'b0, src0_en = 1'b0, src0_last = 1'b0;
    logic [23:0] src0_rgb = '0;
    logic        src1_req = 1'b0, src1_en = 1'b0, src1_last = 1'b0;
    logic [23:0] src1_rgb = '0;
    logic        src0_gnt, src1_gnt, gb_en, gb_last, gb_sel, timeout_err;
    logic [23:0] gb_rgb;
    logic [15:0] pkt_words, pkt_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    gearbox_src_arb_24_32 #(
        .FLUSH_CYC (FLUSH),
        .TIMEOUT   (TMO),
        .CNT_W     (16)
    ) dut (
        .clk_200m    (clk_200m),
        .reset_n     (reset_n),
        .src0_req    (src0_req),
        .src0_en     (src0_en),
        .src0_last   (src0_last),
        .src0_rgb    (src0_rgb),
        .src0_gnt    (src0_gnt),
        .src1_req    (src1_req),
        .src1_en     (src1_en),
        .src1_last   (src1_last),
        .src1_rgb    (src1_rgb),
        .src1_gnt    (src1_gnt),
        .gb_en       (gb_en),
        .gb_last     (gb_last),
        .gb_rgb      (gb_rgb),
        .gb_sel      (gb_sel),
        .pkt_words   (pkt_words),
        .pkt_cnt     (pkt_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk_200m = ~clk_200m;

    typedef struct packed {
        logic        r0, e0, l0;
        logic [23:0] d0;
        logic        r1, e1, l1;
        logic [23:0] d1;
        logic        g0, g1, en, last;
        logic [23:0] rgb;
        logic        sel, terr;
        logic [15:0] words, cnt;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {2'b0, src0_gnt, src1_gnt, gb_en, gb_last, gb_rgb, gb_sel, timeout_err,
                pkt_words, pkt_cnt};
    endfunction

    task automatic tick();
        @(posedge clk_200m);
        #1;
    endtask

    task automatic set_idle_inputs();
        src0_req = 0; src0_en = 0; src0_last = 0; src0_rgb = '0;
        src1_req = 0; src1_en = 0; src1_last = 0; src1_rgb = '0;
    endtask

    task automatic do_reset();
        set_idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk_200m);
        #1;
        check("reset_state", outs(), 64'h0);
        reset_n = 1'b1;
    endtask

    function automatic logic [23:0] word(input int s, input int p, input int i);
        return {8'(s + 1), 8'(p), 8'(i)};
    endfunction

    initial begin
        // Single-word packet from src0 while src1 wiggles without being granted, then
        // src1 requests during the flush (ignored) and wins at the first IDLE edge.
        //             r0    e0    l0    d0          r1    e1    l1    d1
        //             g0    g1    en    last  rgb          sel   terr  words  cnt
        tbl[0] = '{1'b1, 1'b0, 1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 24'hffffff,
                   1'b1, 1'b0, 1'b0, 1'b0, 24'h0,      1'b0, 1'b0, 16'd0, 16'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 24'h123456, 1'b0, 1'b0, 1'b0, 24'h0,
                   1'b0, 1'b0, 1'b1, 1'b1, 24'h123456, 1'b0, 1'b0, 16'd1, 16'd1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 24'h0,      1'b0, 1'b1, 1'b1, 24'habcdef,
                   1'b0, 1'b0, 1'b0, 1'b0, 24'h123456, 1'b0, 1'b0, 16'd1, 16'd1};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 24'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 24'h123456, 1'b0, 1'b0, 16'd1, 16'd1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 1'b1, 24'h654321,
                   1'b0, 1'b0, 1'b0, 1'b0, 24'h123456, 1'b0, 1'b0, 16'd1, 16'd1};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 24'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 24'h123456, 1'b0, 1'b0, 16'd1, 16'd1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 1'b1, 24'h777777,
                   1'b0, 1'b1, 1'b0, 1'b0, 24'h123456, 1'b1, 1'b0, 16'd1, 16'd1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 1'b1, 24'h0badc0,
                   1'b0, 1'b0, 1'b1, 1'b1, 24'h0badc0, 1'b1, 1'b0, 16'd1, 16'd2};

        // ---- single source, 10-word packet ----
        do_reset();
        src0_req = 1;
        tick();
        check("t1_grant", {src0_gnt, src1_gnt, gb_sel, gb_en}, 4'b1000);
        for (int i = 0; i < 10; i++) begin
            logic [23:0] d;
            d = 24'ha2a1a0 + 24'(i) * 24'h101010;
            src0_en = 1; src0_rgb = d; src0_last = (i == 9);
            tick();
            check("t1_word", {gb_en, gb_last, gb_rgb, src0_gnt},
                  {1'b1, (i == 9), d, (i != 9)});
        end
        src0_req = 0; src0_en = 0; src0_last = 0;
        check("t1_counts", {pkt_words, pkt_cnt}, {16'd10, 16'd1});
        for (int k = 0; k < FLUSH; k++) begin
            tick();
            check("t1_flush", {gb_en, gb_last, src0_gnt}, 3'b000);
        end

        // ---- both sources loaded: strict alternation, flush gap before each grant ----
        begin
            int idx[2];
            int pk[2];
            int done_pk;
            int since;
            logic g0, g1;
            logic [23:0] exp_rgb;
            int order[$];
            idx = '{0, 0}; pk = '{0, 0}; done_pk = 0; since = -1;
            do_reset();
            src0_req = 1; src1_req = 1; src0_en = 1; src1_en = 1;
            for (int cyc = 0; cyc < 200 && done_pk < 3; cyc++) begin
                src0_rgb = word(0, pk[0], idx[0]); src0_last = (idx[0] == 3);
                src1_rgb = word(1, pk[1], idx[1]); src1_last = (idx[1] == 3);
                g0 = src0_gnt; g1 = src1_gnt;
                exp_rgb = g1 ? src1_rgb : src0_rgb;
                tick();
                if (g0 | g1)
                    check("rr_data", {gb_en, gb_sel, gb_last, gb_rgb},
                          {1'b1, g1, (g1 ? idx[1] == 3 : idx[0] == 3), exp_rgb});
                else
                    check("rr_idle", {31'b0, gb_en}, 32'b0);
                if (since >= 0) since++;
                if ((src0_gnt | src1_gnt) && !(g0 | g1)) begin
                    order.push_back(int'(src1_gnt));
                    if (since >= 0) check("rr_gap", since, FLUSH + 1);
                    since = -1;
                end
                for (int s = 0; s < 2; s++) begin
                    if ((s == 0) ? g0 : g1) begin
                        idx[s]++;
                        if (idx[s] == 4) begin
                            idx[s] = 0; pk[s]++; done_pk++; since = 0;
                        end
                    end
                end
            end
            check("rr_done", done_pk, 3);
            check("rr_order", {order.size(), (order.size() == 3) ? {order[0], order[1], order[2]}
                               : 96'h0}, {32'd3, 32'd0, 32'd1, 32'd0});
            check("rr_count", pkt_cnt, 3);
        end

        // ---- src1 packet with enable pattern 0011..., 8 words ----
        begin
            int j;
            logic [23:0] exp_rgb;
            j = 0; exp_rgb = '0;
            do_reset();
            src1_req = 1;
            tick();
            check("t3_grant", {src0_gnt, src1_gnt, gb_sel}, 3'b011);
            for (int c = 0; c < 40 && j < 8; c++) begin
                src1_en = ((c % 4) >= 2);
                src1_rgb = src1_en ? 24'h300000 + 24'(j) : 24'hdeadbe;
                src1_last = src1_en && (j == 7);
                if (src1_en) exp_rgb = src1_rgb;
                tick();
                check("t3_word", {gb_en, gb_last, timeout_err, gb_rgb},
                      {src1_en, src1_last, 1'b0, exp_rgb});
                if (src1_en) j++;
            end
            set_idle_inputs();
            check("t3_counts", {pkt_words, pkt_cnt}, {16'd8, 16'd1});
        end

        // ---- table-driven: single-word packet, ignored src1 inputs, FLUSH sampling ----
        do_reset();
        for (int i = 0; i < 8; i++) begin
            src0_req = tbl[i].r0; src0_en = tbl[i].e0; src0_last = tbl[i].l0;
            src0_rgb = tbl[i].d0;
            src1_req = tbl[i].r1; src1_en = tbl[i].e1; src1_last = tbl[i].l1;
            src1_rgb = tbl[i].d1;
            tick();
            check($sformatf("tbl_row%0d", i), outs(),
                  {2'b0, tbl[i].g0, tbl[i].g1, tbl[i].en, tbl[i].last, tbl[i].rgb,
                   tbl[i].sel, tbl[i].terr, tbl[i].words, tbl[i].cnt});
        end

        // ---- stall timeout on src0, src1 takes over after the flush ----
        do_reset();
        src0_req = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            src0_en = 1; src0_rgb = 24'h400001 + 24'(i);
            tick();
        end
        src0_en = 0; src0_req = 0; src1_req = 1;
        for (int k = 1; k <= TMO; k++) begin
            tick();
            if (k < TMO)
                check("to_wait", {gb_en, timeout_err, src0_gnt, src1_gnt}, 4'b0010);
            else
                check("to_dummy", {gb_en, gb_last, gb_rgb, timeout_err, src0_gnt},
                      {1'b1, 1'b1, 24'h000000, 1'b1, 1'b0});
        end
        tick();
        check("to_pulse", {timeout_err, gb_en}, 2'b00);
        check("to_counts", {pkt_words, pkt_cnt}, {16'd4, 16'd1});
        for (int k = 2; k <= FLUSH + 1; k++) begin
            tick();
            check("to_next_grant", {src1_gnt, src0_gnt}, {(k == FLUSH + 1), 1'b0});
        end

        // ---- reset in the middle of a src1 packet ----
        for (int i = 0; i < 5; i++) begin
            src1_en = 1; src1_rgb = 24'h500000 + 24'(i); src1_last = 0;
            tick();
        end
        check("mid_pre", {gb_en, src1_gnt, pkt_cnt}, {1'b1, 1'b1, 16'd1});
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_async", outs(), 64'h0);
        src0_req = 1; src1_req = 1; src1_en = 0;
        @(posedge clk_200m);
        #1;
        check("mid_hold", outs(), 64'h0);
        reset_n = 1'b1;
        tick();
        check("mid_tie", {src0_gnt, src1_gnt, gb_sel, gb_en, pkt_cnt}, {4'b1000, 16'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
